frame_queue_reader: RTL

Consumer end of the 17-bit frame queue that the pattern generator and camera capture paths write. It pops words from the FIFO and decodes the marker words: frame start, row start and frame end. It emits a 16-bit pixel stream with valid/ready handshake, x/y coordinates and frame-level strobes, and it resynchronises on malformed streams. It feeds the LCD/framebuffer writer.

---
 rtl/frame_stream_pkg.sv | 31 +++
 rtl/stream_skid_buffer.sv | 58 +++++
 rtl/frame_queue_reader.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/frame_stream_pkg.sv
// rtl/frame_stream_pkg.sv - shared frame queue word format, reader states and skid entry layout
package frame_stream_pkg;

  localparam int WORD_W  = 17;
  localparam int COORD_W = 11;

  localparam logic [WORD_W-1:0] FRAME_START_WORD = 17'h10000;
  localparam logic [WORD_W-1:0] ROW_START_WORD   = 17'h10001;
  localparam logic [WORD_W-1:0] FRAME_END_WORD   = 17'h1FFFF;

  typedef enum logic [1:0] {
    WAIT_FRAME,
    WAIT_ROW,
    ROW_PIXELS,
    WAIT_END
  } reader_state_t;

  typedef struct packed {
    logic [15:0]        data;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               first;
  } pixel_entry_t;

  localparam int ENTRY_W = $bits(pixel_entry_t);

  function automatic logic is_marker(input logic [WORD_W-1:0] word);
    return word[WORD_W-1];
  endfunction

endpackage

// File: rtl/stream_skid_buffer.sv
// rtl/stream_skid_buffer.sv - two-entry output buffer; head entry is registered and held while stalled
module stream_skid_buffer
  import frame_stream_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               push,
  input  logic [ENTRY_W-1:0] push_entry,
  input  logic               pop_ready,
  output logic               out_valid,
  output logic [ENTRY_W-1:0] out_entry,
  output logic [1:0]         occupancy
);

  logic [ENTRY_W-1:0] entry0;
  logic [ENTRY_W-1:0] entry1;
  logic [1:0]         count;
  logic               pop;
  logic               push_ok;

  assign pop     = (count != 2'd0) && pop_ready;
  assign push_ok = push && (pop || count != 2'd2);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      entry0 <= '0;
      entry1 <= '0;
      count  <= 2'd0;
    end else begin
      case ({push_ok, pop})
        2'b10: begin
          if (count == 2'd0) entry0 <= push_entry;
          else               entry1 <= push_entry;
          count <= count + 2'd1;
        end
        2'b01: begin
          entry0 <= entry1;
          count  <= count - 2'd1;
        end
        2'b11: begin
          // count stays; the new word lands behind whatever remains
          if (count == 2'd1) begin
            entry0 <= push_entry;
          end else begin
            entry0 <= entry1;
            entry1 <= push_entry;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid = (count != 2'd0);
  assign out_entry = entry0;
  assign occupancy = count;

endmodule

// File: rtl/frame_queue_reader.sv
// rtl/frame_queue_reader.sv - pops the frame queue, decodes markers and emits a coordinate-tagged pixel stream
module frame_queue_reader
  import frame_stream_pkg::*;
#(
  parameter int   FRAME_WIDTH       = 480,
  parameter int   FRAME_HEIGHT      = 272,
  parameter logic EXPECT_EXTRA_DATA = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        queue_empty,
  input  logic [16:0] queue_data,
  output logic        queue_rd_en,
  output logic        queue_clk,
  output logic [15:0] pixel_data,
  output logic        pixel_valid,
  input  logic        pixel_ready,
  output logic [10:0] pixel_x,
  output logic [10:0] pixel_y,
  output logic        frame_first,
  output logic        frame_done,
  output logic        protocol_error,
  output logic [7:0]  error_count
);

  localparam logic [10:0] X_LAST = 11'(FRAME_WIDTH - 1);
  localparam logic [10:0] Y_LAST = 11'(FRAME_HEIGHT - 1);
  localparam reader_state_t AFTER_START = EXPECT_EXTRA_DATA ? WAIT_ROW : ROW_PIXELS;

  reader_state_t state;
  logic [10:0]   x_cnt;
  logic [10:0]   y_cnt;
  logic          in_flight;
  logic          is_pixel;
  logic          is_fs;
  logic          is_rs;
  logic          is_fe;
  logic          word_err;
  logic          push;
  logic          pop;
  logic [1:0]    occupancy;
  logic [2:0]    credit;
  pixel_entry_t  push_entry;
  pixel_entry_t  head;
  logic [ENTRY_W-1:0] head_bits;

  assign queue_clk = clk;

  // Credits cover both buffered entries and the word still coming back from the FIFO
  assign pop         = pixel_valid && pixel_ready;
  assign credit      = {1'b0, occupancy} + {2'b00, in_flight} - {2'b00, pop};
  assign queue_rd_en = reset_n && !queue_empty && (credit < 3'd2);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) in_flight <= 1'b0;
    else          in_flight <= queue_rd_en;
  end

  assign is_pixel = !is_marker(queue_data);
  assign is_fs    = (queue_data == FRAME_START_WORD);
  assign is_rs    = (queue_data == ROW_START_WORD);
  assign is_fe    = (queue_data == FRAME_END_WORD);

  always_comb begin
    word_err = 1'b0;
    if (in_flight) begin
      case (state)
        WAIT_FRAME: word_err = !is_fs;
        WAIT_ROW:   word_err = !is_rs;
        ROW_PIXELS: word_err = !is_pixel;
        WAIT_END:   word_err = !is_fe;
        default:    word_err = 1'b0;
      endcase
    end
  end

  assign push             = in_flight && is_pixel && (state == ROW_PIXELS);
  assign push_entry.data  = queue_data[15:0];
  assign push_entry.x     = x_cnt;
  assign push_entry.y     = y_cnt;
  assign push_entry.first = (x_cnt == 11'd0) && (y_cnt == 11'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= WAIT_FRAME;
      x_cnt          <= 11'd0;
      y_cnt          <= 11'd0;
      frame_done     <= 1'b0;
      protocol_error <= 1'b0;
      error_count    <= 8'd0;
    end else begin
      frame_done     <= 1'b0;
      protocol_error <= word_err;
      if (word_err && error_count != 8'hFF) error_count <= error_count + 8'd1;
      if (in_flight) begin
        case (state)
          WAIT_FRAME: begin
            if (is_fs) begin
              x_cnt <= 11'd0;
              y_cnt <= 11'd0;
              state <= AFTER_START;
            end
          end
          WAIT_ROW: begin
            if (is_fs) begin
              x_cnt <= 11'd0;
              y_cnt <= 11'd0;
            end else if (is_rs) begin
              x_cnt <= 11'd0;
              state <= ROW_PIXELS;
            end else if (is_fe) begin
              state <= WAIT_FRAME;
            end
          end
          ROW_PIXELS: begin
            if (is_pixel) begin
              if (x_cnt == X_LAST) begin
                x_cnt <= 11'd0;
                if (y_cnt != Y_LAST) begin
                  y_cnt <= y_cnt + 11'd1;
                  state <= AFTER_START;
                end else if (EXPECT_EXTRA_DATA) begin
                  state <= WAIT_END;
                end else begin
                  frame_done <= 1'b1;
                  state      <= WAIT_FRAME;
                end
              end else begin
                x_cnt <= x_cnt + 11'd1;
              end
            end else if (is_rs) begin
              // short row: the marker opens the next row
              x_cnt <= 11'd0;
              if (y_cnt != Y_LAST) y_cnt <= y_cnt + 11'd1;
              else                 state <= WAIT_END;
            end else if (is_fe) begin
              state <= WAIT_FRAME;
            end else if (is_fs) begin
              x_cnt <= 11'd0;
              y_cnt <= 11'd0;
              state <= AFTER_START;
            end
          end
          WAIT_END: begin
            if (is_fe) begin
              frame_done <= 1'b1;
              state      <= WAIT_FRAME;
            end else if (is_fs) begin
              x_cnt <= 11'd0;
              y_cnt <= 11'd0;
              state <= AFTER_START;
            end
          end
          default: state <= WAIT_FRAME;
        endcase
      end
    end
  end

  stream_skid_buffer u_skid (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (push),
    .push_entry (push_entry),
    .pop_ready  (pixel_ready),
    .out_valid  (pixel_valid),
    .out_entry  (head_bits),
    .occupancy  (occupancy)
  );

  assign head        = pixel_entry_t'(head_bits);
  assign pixel_data  = head.data;
  assign pixel_x     = head.x;
  assign pixel_y     = head.y;
  assign frame_first = head.first;

endmodule
